fetch_stage_hs: RTL and testbench

- Parametrised successor to the single-cycle fetch stage of the 5-stage RISC-V pipeline.
- Owns the F-stage program counter (PCF) and the F/D pipeline register.
- Talks to instruction memory through a valid/ready request channel and a valid response channel, so memory latency can vary.
- Adds StallF/StallD/FlushD hazard control, a D-stage valid bit, and safe discard of in-flight fetches on redirect.

---
 rtl/pipeline_pkg.sv | 15 +
 rtl/fetch_pc_gen.sv | 30 +++
 rtl/fetch_stage_hs.sv | 119 +++++++++++
 tb/tb_fetch_stage_hs.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipelined RISC-V fetch path: FSM encoding and
// default widths/constants used by the fetch stage and its PC generator.
package pipeline_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam int          DEF_XLEN      = 32;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_pc_gen.sv
// F-stage program counter with next-PC priority redirect > advance > hold.
module fetch_pc_gen
  import pipeline_pkg::*;
#(
  parameter int              XLEN     = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] target,
  input  logic            advance,
  output logic [XLEN-1:0] pcf,
  output logic [XLEN-1:0] pcf_plus4
);

  // Modulo 2^XLEN, so the PC wraps naturally.
  assign pcf_plus4 = pcf + XLEN'(4);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcf <= RESET_PC;
    end else if (redirect) begin
      pcf <= target;
    end else if (advance) begin
      pcf <= pcf_plus4;
    end
  end

endmodule

// File: rtl/fetch_stage_hs.sv
// Fetch stage with valid/ready instruction-memory handshake, one outstanding
// request, hazard stall/flush control and discard of fetches killed by redirect.
module fetch_stage_hs
  import pipeline_pkg::*;
#(
  parameter int              XLEN      = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(DEF_RESET_PC),
  parameter logic [31:0]     NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  fetch_state_e    state, state_nxt;
  logic            discard, discard_nxt;
  logic [31:0]     hold_buf;
  logic [XLEN-1:0] pcf, pcf_plus4;
  logic            handshake, wait_rsp, load_rsp, load_hold, load_due, capture, advance;

  fetch_pc_gen #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk       (clk),
    .rst       (rst),
    .redirect  (PCSrcE),
    .target    (PCTargetE),
    .advance   (advance),
    .pcf       (pcf),
    .pcf_plus4 (pcf_plus4)
  );

  assign imem_req_valid = rst && (state == REQ) && !StallF;
  assign imem_addr      = pcf;
  assign handshake      = imem_req_valid && imem_req_ready;

  // A redirect in the response cycle kills the word just like a pending discard.
  assign wait_rsp  = (state == WAIT) && imem_rsp_valid && !discard && !PCSrcE;
  assign load_rsp  = wait_rsp && !StallD;
  assign capture   = wait_rsp && StallD;
  assign load_hold = (state == HOLD) && !PCSrcE && !StallD;
  assign load_due  = load_rsp || load_hold;
  assign advance   = load_due && !StallF;

  always_comb begin
    state_nxt   = state;
    discard_nxt = discard;
    unique case (state)
      REQ: begin
        if (handshake) begin
          state_nxt   = WAIT;
          discard_nxt = PCSrcE;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          discard_nxt = 1'b0;
          state_nxt   = capture ? HOLD : REQ;
        end else if (PCSrcE) begin
          discard_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (PCSrcE || !StallD) state_nxt = REQ;
      end
      default: state_nxt = REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= REQ;
      discard <= 1'b0;
    end else begin
      state   <= state_nxt;
      discard <= discard_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) hold_buf <= imem_rsp_data;
  end

  // F/D register: redirect/flush bubble beats load; an idle, unstalled D gets a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (PCSrcE || FlushD) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (load_due) begin
      InstrD   <= load_rsp ? imem_rsp_data : hold_buf;
      PCD      <= pcf;
      PCPlus4D <= pcf_plus4;
      ValidD   <= 1'b1;
    end else if (!StallD) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage_hs.sv
// Directed bench for fetch_stage_hs with a variable-latency memory responder.
module tb_fetch_stage_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrcE, StallF, StallD, FlushD;
  logic [31:0] PCTargetE;
  logic        imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_req_valid, ValidD;
  logic [31:0] imem_addr, InstrD, PCD, PCPlus4D;
  logic        w_req_valid, w_ValidD;
  logic [31:0] w_addr, w_InstrD, w_PCD, w_PCPlus4D;

  int          checks = 0;
  int          errors = 0;
  int          lat = 1;
  int          cnt = 0;
  bit          pend = 1'b0;
  logic [31:0] paddr = '0;

  always #5 clk = ~clk;

  fetch_stage_hs dut (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  // Wrap-around instance; its FSM timing matches dut, so it shares the responder.
  fetch_stage_hs #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(w_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .InstrD(w_InstrD), .PCD(w_PCD),
    .PCPlus4D(w_PCPlus4D), .ValidD(w_ValidD)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h0050_0093 ^ {a[13:0], 18'h0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (imem_req_valid && imem_req_ready) begin
      pend  = 1'b1;
      cnt   = lat;
      paddr = imem_addr;
    end
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word(paddr);
        pend           = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; PCSrcE = 1'b0; PCTargetE = '0; StallF = 1'b0; StallD = 1'b0;
    FlushD = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    #2 rst = 1'b0;
    tick();
    chk("rst_valid", ValidD, 1'b0);
    chk("rst_instr", InstrD, 32'h0000_0013);
    chk("rst_pcd", PCD, 32'h0);
    chk("rst_req", imem_req_valid, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    chk("rel_req", imem_req_valid, 1'b1);
    chk("rel_addr", imem_addr, 32'h0);
    chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);

    tick();
    chk("wait_noreq", imem_req_valid, 1'b0);
    tick();
    chk("i0_instr", InstrD, 32'h0050_0093);
    chk("i0_pcd", PCD, 32'h0);
    chk("i0_pc4", PCPlus4D, 32'h4);
    chk("i0_valid", ValidD, 1'b1);
    chk("wrap_pcd", w_PCD, 32'hFFFF_FFFC);
    chk("wrap_pc4", w_PCPlus4D, 32'h0);
    chk("wrap_next", w_addr, 32'h0);
    tick();
    chk("gap_valid", ValidD, 1'b0);
    chk("gap_pcd_held", PCD, 32'h0);
    tick();
    chk("i4_instr", InstrD, 32'h0040_0093);
    chk("i4_pcd", PCD, 32'h4);

    // Memory not ready for 3 cycles at PCF=8.
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("nrdy_addr", imem_addr, 32'h8);
      chk("nrdy_valid", ValidD, 1'b0);
    end
    imem_req_ready = 1'b1;
    tick();
    chk("nrdy_wait", ValidD, 1'b0);
    tick();
    chk("i8_instr", InstrD, 32'h0070_0093);
    chk("i8_pcd", PCD, 32'h8);
    chk("i8_pc4", PCPlus4D, 32'hC);

    // StallD for 4 cycles while the 0x0C response arrives.
    StallD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_instr", InstrD, 32'h0070_0093);
      chk("stall_pcd", PCD, 32'h8);
      chk("stall_valid", ValidD, 1'b1);
      if (i > 0) chk("hold_noreq", imem_req_valid, 1'b0);
    end
    StallD = 1'b0;
    tick();
    chk("ic_instr", InstrD, 32'h0060_0093);
    chk("ic_pcd", PCD, 32'hC);
    chk("ic_pc4", PCPlus4D, 32'h10);

    // Redirect to 0x40 while fetch of 0x10 is outstanding (2-cycle memory).
    lat = 2;
    tick();
    PCSrcE = 1'b1; PCTargetE = 32'h40;
    tick();
    PCSrcE = 1'b0; PCTargetE = '0;
    #1;
    chk("redir_bubble", InstrD, 32'h0000_0013);
    chk("redir_valid", ValidD, 1'b0);
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_noreq", imem_req_valid, 1'b0);
    tick();
    chk("drop_valid", ValidD, 1'b0);
    chk("drop_req", imem_req_valid, 1'b1);
    tick();
    chk("r40_wait1", ValidD, 1'b0);
    tick();
    chk("r40_wait2", ValidD, 1'b0);
    tick();
    chk("i40_instr", InstrD, 32'h0150_0093);
    chk("i40_pcd", PCD, 32'h40);
    chk("i40_valid", ValidD, 1'b1);
    lat = 1;

    // FlushD together with StallD.
    StallD = 1'b1; FlushD = 1'b1;
    tick();
    StallD = 1'b0; FlushD = 1'b0;
    chk("flush_instr", InstrD, 32'h0000_0013);
    chk("flush_valid", ValidD, 1'b0);
    chk("flush_pcd", PCD, 32'h40);
    tick();
    chk("i44_instr", InstrD, 32'h0140_0093);
    chk("i44_pcd", PCD, 32'h44);

    // FlushD on a due load: word lost, PCF still advances.
    tick();
    FlushD = 1'b1;
    tick();
    FlushD = 1'b0;
    chk("fl_load_valid", ValidD, 1'b0);
    chk("fl_load_pcd", PCD, 32'h44);
    chk("fl_load_addr", imem_addr, 32'h4C);

    // StallF, then a redirect that overrides it.
    StallF = 1'b1;
    #1;
    chk("stallf_req", imem_req_valid, 1'b0);
    tick();
    chk("stallf_addr", imem_addr, 32'h4C);
    PCSrcE = 1'b1; PCTargetE = 32'h80;
    tick();
    PCSrcE = 1'b0; PCTargetE = '0;
    #1;
    chk("stallf_redir", imem_addr, 32'h80);
    chk("stallf_req2", imem_req_valid, 1'b0);
    StallF = 1'b0;
    tick();
    tick();
    chk("i80_instr", InstrD, 32'h0250_0093);
    chk("i80_pc4", PCPlus4D, 32'h84);

    // Reset with a fetch in flight; stray response after release is ignored.
    tick();
    rst = 1'b0;
    #1;
    chk("mrst_req", imem_req_valid, 1'b0);
    chk("mrst_valid", ValidD, 1'b0);
    chk("mrst_pcd", PCD, 32'h0);
    chk("mrst_addr", imem_addr, 32'h0);
    tick();
    rst = 1'b1; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    chk("stray_valid", ValidD, 1'b0);
    chk("stray_addr", imem_addr, 32'h0);
    imem_req_ready = 1'b1;
    tick();
    tick();
    chk("post_instr", InstrD, 32'h0050_0093);
    chk("post_pcd", PCD, 32'h0);
    chk("post_valid", ValidD, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
